// File: rtl/mkio_tx_scheduler.sv
// MKIO transmit scheduler: queues {cd,data} words and launches them to the line transmitter.
// Define MKIO_TX_GAP_EN to insert GAP_CYCLES idle cycles before command words.
module mkio_tx_scheduler #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned GAP_CYCLES = 64,
  parameter int unsigned TMO_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        i_wr_en,
  input  logic                        i_wr_cd,
  input  logic [15:0]                 i_wr_data,
  input  logic                        i_enable,
  input  logic                        i_abort,
  input  logic                        i_clr_err,
  input  logic                        i_busy_send,
  output logic                        o_imp_send,
  output logic                        o_cd_send,
  output logic [15:0]                 o_data_send,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [$clog2(FIFO_DEPTH):0] o_level,
  output logic                        o_active,
  output logic                        o_err_ovf,
  output logic                        o_err_tmo
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = $clog2(TMO_CYCLES + 1);
  localparam int unsigned EW = 17;

`ifdef MKIO_TX_GAP_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0, ST_GAP = 3'd1, ST_LOAD = 3'd2, ST_WAIT_BUSY = 3'd3, ST_WAIT_DONE = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0, ST_LOAD = 3'd2, ST_WAIT_BUSY = 3'd3, ST_WAIT_DONE = 3'd4
  } state_t;
`endif

  state_t        r_state;
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic [LW-1:0] w_level_nxt;
  logic          r_full;
  logic          r_empty;
  logic          r_imp_send;
  logic          r_cd_send;
  logic [15:0]   r_data_send;
  logic          r_active;
  logic          r_err_ovf;
  logic          r_err_tmo;
  logic [TW-1:0] r_tmo_cnt;
  logic [EW-1:0] w_head;
  logic          w_push;
  logic          w_ovf;
  logic          w_can;
  logic          w_launch;
  logic          w_tmo_evt;

  assign w_head    = r_mem[r_rptr];
  assign w_push    = i_wr_en && !r_full && !i_abort;
  assign w_ovf     = i_wr_en && r_full && !i_abort;
  assign w_can     = i_enable && !r_empty && !i_abort && !i_busy_send;
  assign w_tmo_evt = (r_state == ST_WAIT_BUSY) && !i_busy_send &&
                     (r_tmo_cnt == TW'(TMO_CYCLES - 1));

`ifdef MKIO_TX_GAP_EN
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  logic [GW-1:0] r_gap_cnt;
  logic          r_gap_ok;
  logic          w_gap_done;
  logic          w_head_cd;
  logic          w_to_gap;

  assign w_head_cd  = w_head[16];
  assign w_gap_done = r_gap_ok || (r_gap_cnt == GW'(GAP_CYCLES - 1));
  assign w_launch   = w_can && (((r_state == ST_IDLE) && (!w_head_cd || w_gap_done)) ||
                                ((r_state == ST_GAP) && w_gap_done) ||
                                ((r_state == ST_WAIT_DONE) && !w_head_cd));
  assign w_to_gap   = w_can && w_head_cd &&
                      (((r_state == ST_IDLE) && !w_gap_done) || (r_state == ST_WAIT_DONE));

  // Cycles since the last word left the line; r_gap_ok once a full gap has elapsed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gap_cnt <= '0;
      r_gap_ok  <= 1'b1;
    end else if ((r_state == ST_WAIT_DONE) && !i_busy_send) begin
      r_gap_cnt <= '0;
      r_gap_ok  <= 1'b0;
    end else if ((r_state == ST_GAP) && (!i_enable || i_abort)) begin
      r_gap_cnt <= '0;
    end else if (!r_gap_ok) begin
      if (w_gap_done) begin
        r_gap_cnt <= '0;
        r_gap_ok  <= 1'b1;
      end else begin
        r_gap_cnt <= r_gap_cnt + GW'(1);
      end
    end
  end
`else
  assign w_launch = w_can && ((r_state == ST_IDLE) || (r_state == ST_WAIT_DONE));
`endif

  always_comb begin
    w_level_nxt = r_level;
    if (i_abort) begin
      w_level_nxt = '0;
    end else if (w_push && !w_launch) begin
      w_level_nxt = r_level + LW'(1);
    end else if (!w_push && w_launch) begin
      w_level_nxt = r_level - LW'(1);
    end
  end

  // Queue pointers and status; the head is popped on the edge that enters LOAD.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LW'(FIFO_DEPTH));
      r_empty <= (w_level_nxt == '0);
      if (i_abort) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push)   r_wptr <= r_wptr + AW'(1);
        if (w_launch) r_rptr <= r_rptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {i_wr_cd, i_wr_data};
  end

  // Launch FSM with registered strobe, payload, activity and sticky error flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_imp_send  <= 1'b0;
      r_cd_send   <= 1'b0;
      r_data_send <= '0;
      r_active    <= 1'b0;
      r_tmo_cnt   <= '0;
      r_err_ovf   <= 1'b0;
      r_err_tmo   <= 1'b0;
    end else begin
      r_imp_send <= 1'b0;
      if (w_launch) begin
        r_state     <= ST_LOAD;
        r_imp_send  <= 1'b1;
        r_cd_send   <= w_head[16];
        r_data_send <= w_head[15:0];
        r_active    <= 1'b1;
`ifdef MKIO_TX_GAP_EN
      end else if (w_to_gap) begin
        r_state  <= ST_GAP;
        r_active <= 1'b1;
`endif
      end else begin
        case (r_state)
`ifdef MKIO_TX_GAP_EN
          ST_GAP: begin
            if (!i_enable || i_abort) begin
              r_state  <= ST_IDLE;
              r_active <= 1'b0;
            end
          end
`endif
          ST_LOAD: begin
            r_state   <= ST_WAIT_BUSY;
            r_tmo_cnt <= '0;
          end
          ST_WAIT_BUSY: begin
            if (i_busy_send) begin
              r_state <= ST_WAIT_DONE;
            end else if (w_tmo_evt) begin
              r_state  <= ST_IDLE;
              r_active <= 1'b0;
            end else begin
              r_tmo_cnt <= r_tmo_cnt + TW'(1);
            end
          end
          ST_WAIT_DONE: begin
            if (!i_busy_send) begin
              r_state  <= ST_IDLE;
              r_active <= 1'b0;
            end
          end
          default: ;
        endcase
      end

      if (w_ovf)          r_err_ovf <= 1'b1;
      else if (i_clr_err) r_err_ovf <= 1'b0;
      if (w_tmo_evt)      r_err_tmo <= 1'b1;
      else if (i_clr_err) r_err_tmo <= 1'b0;
    end
  end

  assign o_imp_send  = r_imp_send;
  assign o_cd_send   = r_cd_send;
  assign o_data_send = r_data_send;
  assign o_full      = r_full;
  assign o_empty     = r_empty;
  assign o_level     = r_level;
  assign o_active    = r_active;
  assign o_err_ovf   = r_err_ovf;
  assign o_err_tmo   = r_err_tmo;

endmodule

// File: doc/mkio_tx_scheduler.md
MKIO_TX_SCHEDULER -- requirements
Module: mkio_tx_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, word-queue depth; power of 2, range 2..64.
REQ-002 Parameter GAP_CYCLES, default 64, idle clk cycles inserted before a command word (4 us at 16 MHz).
REQ-003 Parameter TMO_CYCLES, default 4, max cycles from imp_send to busy_send=1.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 wr_en  in  1  push {wr_cd, wr_data} into queue.
REQ-007 wr_cd  in  1  1 = command/status sync, 0 = data sync.
REQ-008 wr_data  in  16  word to transmit.
REQ-009 enable  in  1  1 = scheduler may launch words.
REQ-010 abort  in  1  flush queue; finish in-flight word only.
REQ-011 clr_err  in  1  clears sticky error flags.
REQ-012 busy_send  in  1  transmitter line-busy status.
REQ-013 imp_send  out  1  one-cycle launch strobe to transmitter.
REQ-014 cd_send  out  1  sync type for launched word.
REQ-015 data_send  out  16  launched word; held until next launch.
REQ-016 full / empty  out  1 each  queue status.
REQ-017 level  out  clog2(FIFO_DEPTH)+1  queued entry count.
REQ-018 active  out  1  1 whenever state != IDLE.
REQ-019 err_ovf / err_tmo  out  1 each  sticky overflow / transmitter-timeout flags.

Function
REQ-020 Queue SHALL be synchronous FIFO of 17-bit entries {cd,data}, wrap-around pointers, level = writes - pops.
REQ-021 wr_en while full SHALL discard the entry and set err_ovf, even if a pop occurs that cycle.
REQ-022 FSM states SHALL be IDLE, GAP, LOAD, WAIT_BUSY, WAIT_DONE.
REQ-023 IDLE -> LOAD when enable=1 and !empty; if head cd=1 and a word completed <GAP_CYCLES ago, IDLE -> GAP instead.
REQ-024 LOAD SHALL last exactly one cycle: imp_send=1, cd_send/data_send = head entry (registered on entry to LOAD), head popped; -> WAIT_BUSY.
REQ-025 WAIT_BUSY -> WAIT_DONE on busy_send=1; after TMO_CYCLES cycles without it, set err_tmo -> IDLE.
REQ-026 WAIT_DONE -> on busy_send=0: queue empty or enable=0 -> IDLE; head cd=0 -> LOAD (contiguous data words, no gap); head cd=1 -> GAP.
REQ-027 GAP SHALL count GAP_CYCLES cycles then -> LOAD; enable=0 or abort in GAP -> IDLE, counter cleared.
REQ-028 Latency: write at edge k into empty queue, state IDLE, enable=1, gap satisfied -> imp_send high for the cycle following edge k+1.
REQ-029 abort SHALL zero the queue in the sampled cycle; abort wins over simultaneous wr_en (entry discarded, no err_ovf); in-flight word finishes, then IDLE.
REQ-030 imp_send SHALL never assert while busy_send=1.
REQ-031 clr_err SHALL clear both flags; a simultaneous new error event wins (flag stays 1).

Reset
REQ-032 reset_n=0 SHALL asynchronously force: state IDLE, queue empty (level 0, empty=1, full=0), imp_send=0, cd_send=0, data_send=0, active=0, err_ovf=0, err_tmo=0, gap counter cleared, gap treated as satisfied.
REQ-033 Reset mid-transmission SHALL abandon the word; no imp_send until after release and a new write.

Configuration
REQ-034 Macro MKIO_TX_GAP_EN: defined -> GAP state and GAP_CYCLES insertion per REQ-023/026/027; undefined -> GAP state absent, command words launched like data words (WAIT_DONE -> LOAD directly), gap counter not synthesized.

Verification
REQ-035 Bench model: busy_send rises 1 cycle after imp_send, stays high 320 cycles.
REQ-036 Write {1,16'h0821}, then {0,16'hAAAA},{0,16'h5555}, enable=1 -> three imp_send pulses, cd 1,0,0, data in order; pulses 2,3 one cycle after busy_send falls.
REQ-037 Queue {0,16'h1234},{1,16'hBEEF} with MKIO_TX_GAP_EN -> second imp_send exactly GAP_CYCLES+1 cycles after busy_send falls; without macro -> 1 cycle after.
REQ-038 Nine writes with enable=0, FIFO_DEPTH=8 -> full=1, level=8, err_ovf=1, 9th entry never sent; clr_err -> err_ovf=0.
REQ-039 busy_send tied 0, one queued word -> single imp_send, err_tmo=1 after TMO_CYCLES, active=0, no retry.
REQ-040 abort during second of four queued words -> that word completes, remaining two never sent, level=0, active=0; reset_n pulse mid-word -> all outputs at REQ-032 values immediately.
